// File: rtl/serializer_pkg.sv
// Shared types and default sizing for the parallel-in/serial-out serializer.
package serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int SER_WIDTH = 8;
   localparam int SER_CNT_W = 8;

endpackage

// File: rtl/ser_hold_slot.sv
// One-entry holding register: a word is written on accept and released on drain.
module ser_hold_slot
   import serializer_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             accept,
   input  logic             drain,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         full <= 1'b0;
      else if (accept)
         full <= 1'b1;
      else if (drain)
         full <= 1'b0;
   end

   // Payload needs no reset; it is only observed while full is set.
   always_ff @(posedge clk) begin
      if (accept)
         data <= data_in;
   end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer: one held word, shifted out one bit per shift_en strobe.
module piso_bit_serializer
   import serializer_pkg::*;
#(
   parameter int   WIDTH      = SER_WIDTH,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0,
   parameter int   CNT_W      = SER_CNT_W
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             shift_en,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic [CNT_W-1:0] words_sent
);

   localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   ser_state_t       state, state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] hold_data;
   logic [BCW-1:0]   bit_cnt;
   logic             hold_full;
   logic             accept, drain;
   logic             load, advance, done;

   ser_hold_slot #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .accept  (accept),
      .drain   (drain),
      .data_in (data_in),
      .data    (hold_data),
      .full    (hold_full)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      done       = (state == SHIFT) && shift_en && (bit_cnt == LAST_BIT);
      advance    = (state == SHIFT) && shift_en && (bit_cnt != LAST_BIT);
      load       = hold_full && ((state == IDLE) || done);
      state_next = state;
      case (state)
         IDLE:    if (hold_full) state_next = SHIFT;
         SHIFT:   if (done && !hold_full) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      data_ready = !hold_full;
      accept     = data_valid && !hold_full;
      drain      = load;
      busy       = (state == SHIFT) || hold_full;
   end

   // A load on the completing strobe keeps dout_valid high, so words stream without a gap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg  <= '0;
         bit_cnt    <= '0;
         dout       <= IDLE_LEVEL;
         dout_valid <= 1'b0;
         words_sent <= '0;
      end else begin
         if (load) begin
            shift_reg  <= hold_data;
            bit_cnt    <= '0;
            dout       <= MSB_FIRST ? hold_data[WIDTH-1] : hold_data[0];
            dout_valid <= 1'b1;
         end else if (advance) begin
            shift_reg  <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
            bit_cnt    <= bit_cnt + BCW'(1);
            dout       <= MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1];
         end else if (done) begin
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
         end
         if (done)
            words_sent <= words_sent + CNT_W'(1);
      end
   end

endmodule
